// File: rtl/xbar_rule_update_ctrl_pkg.sv
// Shared types and register offsets for the crossbar rule update controller.
package xbar_rule_update_ctrl_pkg;

    localparam int unsigned CFG_ADDR_W = 8;
    localparam int unsigned CFG_DATA_W = 32;

    localparam logic [CFG_ADDR_W-1:0] RULE_STRIDE = 8'h10;
    localparam logic [CFG_ADDR_W-1:0] CTRL_OFFS   = 8'hF0;
    localparam logic [CFG_ADDR_W-1:0] STATUS_OFFS = 8'hF4;

    localparam logic [1:0] FIELD_IDX   = 2'd0;
    localparam logic [1:0] FIELD_START = 2'd1;
    localparam logic [1:0] FIELD_END   = 2'd2;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLOCK,
        ST_DRAIN,
        ST_SWAP
    } rule_upd_state_e;

endpackage

// File: rtl/tcdm_outstanding_cnt.sv
// Saturating outstanding-transaction counter for one crossbar master.
module tcdm_outstanding_cnt #(
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_next_c,
    output logic overflow_c
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Simultaneous inc/dec cancel; inc at max saturates, dec at zero is dropped.
    always_comb begin
        cnt_d      = cnt_q;
        overflow_c = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) begin
                overflow_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    // Zero flag looks at the post-update value so a final rvalid ends the drain.
    assign zero_next_c = (cnt_d == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xbar_rule_update_ctrl.sv
// Shadow/active address-rule store for the crossbar with a quiesce-and-swap commit sequence.
module xbar_rule_update_ctrl
    import xbar_rule_update_ctrl_pkg::*;
#(
    parameter int unsigned                        NR_MASTER_PORTS = 2,
    parameter int unsigned                        NR_ADDR_RULES   = 2,
    parameter int unsigned                        CNT_WIDTH       = 2,
    parameter addr_map_rule_t [NR_ADDR_RULES-1:0] RESET_RULES     = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 cfg_req_i,
    input  logic                                 cfg_we_i,
    input  logic [CFG_ADDR_W-1:0]                cfg_addr_i,
    input  logic [CFG_DATA_W-1:0]                cfg_wdata_i,
    output logic                                 cfg_gnt_o,
    output logic                                 cfg_rvalid_o,
    output logic [CFG_DATA_W-1:0]                cfg_rdata_o,
    input  logic [NR_MASTER_PORTS-1:0]           mst_req_i,
    input  logic [NR_MASTER_PORTS-1:0]           mst_gnt_i,
    input  logic [NR_MASTER_PORTS-1:0]           mst_rvalid_i,
    output logic                                 mst_block_o,
    output addr_map_rule_t [NR_ADDR_RULES-1:0]   addr_rules_o,
    output logic                                 busy_o,
    output logic                                 update_done_o
);

    rule_upd_state_e state_q, state_d;
    logic            pending_q, pending_d;
    logic            sticky_q;
    logic            busy_q;
    logic            done_q;
    logic            rvalid_q;
    logic [CFG_DATA_W-1:0] rdata_q, rdata_c;

    addr_map_rule_t [NR_ADDR_RULES-1:0] active_q;
    addr_map_rule_t [NR_ADDR_RULES-1:0] shadow_q;

    logic [3:0] rule_sel;
    logic [1:0] field_sel;
    logic       aligned;
    logic       wr_en, rd_en;
    logic       ctrl_hit, status_hit;
    logic       commit_wr_c, sticky_clr_c;
    logic       busy_c, drained_c;

    logic [NR_MASTER_PORTS-1:0] cnt_zero_c;
    logic [NR_MASTER_PORTS-1:0] cnt_ovf_c;

    // Register port decode; misaligned addresses are treated as unmapped.
    assign rule_sel     = cfg_addr_i[7:4];
    assign field_sel    = cfg_addr_i[3:2];
    assign aligned      = (cfg_addr_i[1:0] == 2'b00);
    assign wr_en        = cfg_req_i & cfg_we_i & aligned;
    assign rd_en        = cfg_req_i & ~cfg_we_i & aligned;
    assign ctrl_hit     = (cfg_addr_i == CTRL_OFFS);
    assign status_hit   = (cfg_addr_i == STATUS_OFFS);
    assign commit_wr_c  = wr_en & ctrl_hit & cfg_wdata_i[0];
    assign sticky_clr_c = wr_en & status_hit & cfg_wdata_i[2];
    assign busy_c       = (state_q != ST_IDLE);

    genvar g;
    generate
        for (g = 0; g < NR_MASTER_PORTS; g++) begin : gen_cnt
            tcdm_outstanding_cnt #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_cnt (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .inc_i       (mst_req_i[g] & mst_gnt_i[g]),
                .dec_i       (mst_rvalid_i[g]),
                .zero_next_c (cnt_zero_c[g]),
                .overflow_c  (cnt_ovf_c[g])
            );
        end
    endgenerate

    assign drained_c = (&cnt_zero_c) & ~(|(mst_req_i & mst_gnt_i));

    // Read mux: rule registers return shadow values.
    always_comb begin
        rdata_c = '0;
        if (rd_en) begin
            if (status_hit) begin
                rdata_c = {29'd0, sticky_q, pending_q, busy_c};
            end
            for (int unsigned r = 0; r < NR_ADDR_RULES; r++) begin
                if (rule_sel == 4'(r)) begin
                    case (field_sel)
                        FIELD_IDX:   rdata_c = shadow_q[r].idx;
                        FIELD_START: rdata_c = shadow_q[r].start_addr;
                        FIELD_END:   rdata_c = shadow_q[r].end_addr;
                        default:     rdata_c = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_wr_c || pending_q) begin
                    state_d = ST_BLOCK;
                end
                pending_d = 1'b0;
            end
            ST_BLOCK: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (drained_c) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Commits arriving mid-sequence merge into one follow-up update.
        if ((state_q != ST_IDLE) && commit_wr_c) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_SWAP);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_q <= 1'b0;
        end else if (|cnt_ovf_c) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr_c) begin
            sticky_q <= 1'b0;
        end
    end

    // Shadow writes are accepted in any state; SWAP copies the pre-edge shadow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= RESET_RULES;
            active_q <= RESET_RULES;
        end else begin
            for (int unsigned r = 0; r < NR_ADDR_RULES; r++) begin
                if (wr_en && (rule_sel == 4'(r))) begin
                    case (field_sel)
                        FIELD_IDX:   shadow_q[r].idx        <= cfg_wdata_i;
                        FIELD_START: shadow_q[r].start_addr <= cfg_wdata_i;
                        FIELD_END:   shadow_q[r].end_addr   <= cfg_wdata_i;
                        default:     ;
                    endcase
                end
            end
            if (state_q == ST_SWAP) begin
                active_q <= shadow_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= cfg_req_i;
            rdata_q  <= rdata_c;
        end
    end

    assign cfg_gnt_o     = 1'b1;
    assign cfg_rvalid_o  = rvalid_q;
    assign cfg_rdata_o   = rdata_q;
    assign mst_block_o   = busy_q;
    assign busy_o        = busy_q;
    assign update_done_o = done_q;
    assign addr_rules_o  = active_q;

endmodule

// File: tb/tb_xbar_rule_update_ctrl.sv
// Scoreboard bench for xbar_rule_update_ctrl: directed register and commit sequences.
module tb_xbar_rule_update_ctrl;
    import xbar_rule_update_ctrl_pkg::*;

    localparam int unsigned NM = 2;
    localparam int unsigned NR = 2;
    localparam int unsigned CW = 1;

    // Element [0] is the last entry of the concatenation.
    localparam addr_map_rule_t [NR-1:0] RR = {
        addr_map_rule_t'{idx: 32'd0, start_addr: 32'h1A10_0000, end_addr: 32'h1A12_0000},
        addr_map_rule_t'{idx: 32'd1, start_addr: 32'h1C00_0000, end_addr: 32'h1C08_0000}
    };

    logic                 clk;
    logic                 rst_n;
    logic                 cfg_req, cfg_we;
    logic [7:0]           cfg_addr;
    logic [31:0]          cfg_wdata;
    logic                 cfg_gnt, cfg_rvalid;
    logic [31:0]          cfg_rdata;
    logic [NM-1:0]        mst_req, mst_gnt, mst_rvalid;
    logic                 mst_block, busy, update_done;
    addr_map_rule_t [NR-1:0] addr_rules;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0;
    logic [31:0] rd_q[$];
    int          done_q[$];

    xbar_rule_update_ctrl #(
        .NR_MASTER_PORTS (NM),
        .NR_ADDR_RULES   (NR),
        .CNT_WIDTH       (CW),
        .RESET_RULES     (RR)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_req_i     (cfg_req),
        .cfg_we_i      (cfg_we),
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .cfg_gnt_o     (cfg_gnt),
        .cfg_rvalid_o  (cfg_rvalid),
        .cfg_rdata_o   (cfg_rdata),
        .mst_req_i     (mst_req),
        .mst_gnt_i     (mst_gnt),
        .mst_rvalid_i  (mst_rvalid),
        .mst_block_o   (mst_block),
        .addr_rules_o  (addr_rules),
        .busy_o        (busy),
        .update_done_o (update_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rules(input string name, input addr_map_rule_t [NR-1:0] exp);
        checks++;
        if (addr_rules !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, addr_rules, exp);
        end
    endtask

    // Response monitor: every cfg_rvalid pops one expected rdata.
    always @(negedge clk) begin
        if (rst_n && cfg_rvalid) begin
            if (rd_q.size() == 0) begin
                check("cfg_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                check("cfg_rdata", cfg_rdata, rd_q.pop_front());
            end
        end
    end

    // Swap monitor: every update_done pulse must land on the predicted cycle.
    always @(negedge clk) begin
        if (rst_n && update_done) begin
            if (done_q.size() == 0) begin
                check("update_done_unexpected", 32'd1, 32'd0);
            end else begin
                check("update_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_req    = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = 8'h00;
        cfg_wdata  = 32'h0;
        mst_req    = '0;
        mst_gnt    = '0;
        mst_rvalid = '0;
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [31:0] d);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        rd_q.push_back(32'h0);
    endtask

    task automatic set_rd(input logic [7:0] a, input logic [31:0] exp);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a; cfg_wdata = 32'h0;
        rd_q.push_back(exp);
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        set_wr(a, d); step(); idle_inputs();
    endtask

    task automatic cfg_read(input logic [7:0] a, input logic [31:0] exp);
        set_rd(a, exp); step(); idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check_rules("reset_rules", RR);
        check("reset_block", 32'(mst_block), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(update_done), 32'd0);
        check("reset_rvalid", 32'(cfg_rvalid), 32'd0);
        check("reset_rdata", cfg_rdata, 32'd0);
        check("cfg_gnt", 32'(cfg_gnt), 32'd1);

        // Register map reads of reset shadow
        cfg_read(8'h04, 32'h1C00_0000);
        cfg_read(8'h00, 32'd1);
        cfg_read(8'h14, 32'h1A10_0000);
        cfg_read(8'h18, 32'h1A12_0000);
        cfg_read(8'h0C, 32'h0);
        cfg_read(8'h30, 32'h0);
        cfg_read(8'hF0, 32'h0);
        cfg_read(8'hF4, 32'h0);
        cfg_write(8'h04, 32'h2000_0000);
        cfg_read(8'h04, 32'h2000_0000);

        // Commit with no traffic: busy T+1..T+3, done at T+3, new rules at T+4
        t0 = cyc;
        set_wr(CTRL_OFFS, 32'h1);
        done_q.push_back(t0 + 3);
        step(); idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("c1_busy_k%0d", k), 32'(busy), 32'(k <= 3));
            check($sformatf("c1_block_k%0d", k), 32'(mst_block), 32'(k <= 3));
            check($sformatf("c1_r0start_k%0d", k), addr_rules[0].start_addr,
                  (k == 4) ? 32'h2000_0000 : 32'h1C00_0000);
            step();
        end

        // Commit with master 1 granted in the commit cycle, rvalid at T+5
        cfg_write(8'h18, 32'h1C0F_0000);
        t0 = cyc;
        set_wr(CTRL_OFFS, 32'h1);
        mst_req = 2'b10; mst_gnt = 2'b10;
        done_q.push_back(t0 + 6);
        step();
        for (int k = 1; k <= 7; k++) begin
            idle_inputs();
            if (k == 5) mst_rvalid = 2'b10;
            check($sformatf("c2_busy_k%0d", k), 32'(busy), 32'(k <= 6));
            check($sformatf("c2_r1end_k%0d", k), addr_rules[1].end_addr,
                  (k == 7) ? 32'h1C0F_0000 : 32'h1A12_0000);
            step();
        end
        idle_inputs();

        // Commit during DRAIN merges into a second swap right after IDLE
        t0 = cyc;
        set_wr(CTRL_OFFS, 32'h1);
        mst_req = 2'b01; mst_gnt = 2'b01;
        done_q.push_back(t0 + 5);
        done_q.push_back(t0 + 9);
        step();
        for (int k = 1; k <= 11; k++) begin
            idle_inputs();
            case (k)
                3:  set_wr(CTRL_OFFS, 32'h1);
                4:  begin mst_rvalid = 2'b01; set_rd(STATUS_OFFS, 32'h3); end
                6:  set_wr(8'h00, 32'd5);
                9:  set_wr(8'h08, 32'h1234_5678);
                10: set_rd(STATUS_OFFS, 32'h0);
                11: set_rd(8'h08, 32'h1234_5678);
                default: ;
            endcase
            check($sformatf("c3_busy_k%0d", k), 32'(busy),
                  32'(((k >= 1) && (k <= 5)) || ((k >= 7) && (k <= 9))));
            if (k == 10) begin
                check("c3_r0idx", addr_rules[0].idx, 32'd5);
                check("c3_r0end_swapcycle_write", addr_rules[0].end_addr, 32'h1C08_0000);
                check("c3_r0start", addr_rules[0].start_addr, 32'h2000_0000);
            end
            step();
        end
        idle_inputs();

        // Overflow with CNT_WIDTH=1, clear, re-set, then reset while stuck in DRAIN
        for (int k = 0; k <= 12; k++) begin
            idle_inputs();
            case (k)
                0, 1, 2, 6: begin mst_req = 2'b01; mst_gnt = 2'b01; end
                3:  set_rd(STATUS_OFFS, 32'h4);
                4:  set_wr(STATUS_OFFS, 32'h4);
                5:  set_rd(STATUS_OFFS, 32'h0);
                7:  set_wr(CTRL_OFFS, 32'h1);
                9:  set_wr(CTRL_OFFS, 32'h1);
                10: set_wr(8'h04, 32'hDEAD_0000);
                11: set_rd(STATUS_OFFS, 32'h7);
                default: ;
            endcase
            check($sformatf("c4_busy_k%0d", k), 32'(busy), 32'(k >= 8));
            step();
        end
        idle_inputs();
        check("c4_block_in_drain", 32'(mst_block), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_block", 32'(mst_block), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_rules("rst_rules", RR);
        step(); step();
        rst_n = 1'b1;
        check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
        cfg_read(STATUS_OFFS, 32'h0);
        cfg_read(8'h04, 32'h1C00_0000);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post_rst_busy_k%0d", k), 32'(busy), 32'd0);
            step();
        end

        // Counters cleared by reset: a plain commit completes with minimum latency
        t0 = cyc;
        set_wr(CTRL_OFFS, 32'h1);
        done_q.push_back(t0 + 3);
        step(); idle_inputs();
        step(); step(); step();
        check("final_busy", 32'(busy), 32'd0);
        check_rules("final_rules", RR);
        step();

        check("rd_queue_left", 32'(rd_q.size()), 32'd0);
        check("done_queue_left", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
